// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data bus arbiter.
// Optional feature macro used by the arbiter: BUS_ARB_TIMEOUT_EN.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DATA  = 2'b10
    } arb_state_e;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/bus_arbiter_if.sv
// External memory bus: one request channel driven by the arbiter, one response channel from memory.
interface bus_arbiter_if;

    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid, write, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, write, addr, wdata, wstrb,
        output ready, rdata
    );

endinterface

// File: rtl/bus_arbiter_load_store_align.sv
// Sub-word lane steering: replicates store data, builds byte strobes and extends load data.
module load_store_align
    import bus_arb_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_raw_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted     = load_raw_i >> {offset_i, 3'b000};
        wdata_o     = store_data_i;
        wstrb_o     = 4'b1111;
        load_data_o = shifted;
        // Size code 11 is never issued and falls through to word handling.
        case (size_i)
            SIZE_BYTE: begin
                wdata_o     = {4{store_data_i[7:0]}};
                wstrb_o     = 4'b0001 << offset_i;
                load_data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                wdata_o     = {2{store_data_i[15:0]}};
                wstrb_o     = 4'b0011 << offset_i;
                load_data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the single external bus between instruction fetch and the memory stage.
// Define BUS_ARB_TIMEOUT_EN to abort transfers that wait TIMEOUT_CYCLES for ext ready.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic [31:0] fetch_data,
    output logic        fetch_ready,
    input  logic        mem_load,
    input  logic        mem_store,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_store_data,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    output logic [31:0] mem_load_data,
    output logic        mem_ready,
    output logic        stall_fetch,
    output logic        stall_mem,
    output logic        bus_error,
    bus_arbiter_if.master ext
);

    arb_state_e  state_q, state_d;
    grant_e      last_grant_q, last_grant_d;
    logic        valid_q, valid_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic        mem_req;
    logic        grant_fetch;
    logic        grant_data;
    logic        done;
    logic        timeout;
    logic [31:0] lsa_wdata;
    logic [3:0]  lsa_wstrb;
    logic [31:0] lsa_load;
    logic        unused_fetch_lsb;

    assign mem_req          = mem_load | mem_store;
    assign unused_fetch_lsb = ^fetch_addr[1:0];

    // Requests are held stable until ready, so live inputs steer both store lanes and load extension.
    load_store_align u_align (
        .size_i       (mem_size),
        .signed_i     (mem_signed),
        .offset_i     (mem_address[1:0]),
        .store_data_i (mem_store_data),
        .load_raw_i   (ext.rdata),
        .wdata_o      (lsa_wdata),
        .wstrb_o      (lsa_wstrb),
        .load_data_o  (lsa_load)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (!valid_q || ext.ready || timeout) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout = valid_q && !ext.ready && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    assign done = valid_q && (ext.ready || timeout);

    // A tie goes to whichever requester did not own the previous transfer.
    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (state_q == IDLE) begin
            if (fetch_req && mem_req) begin
                grant_data  = (last_grant_q == GRANT_FETCH);
                grant_fetch = (last_grant_q == GRANT_DATA);
            end else begin
                grant_fetch = fetch_req;
                grant_data  = mem_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_FETCH;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d = DATA;
                end else if (grant_fetch) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (done) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_FETCH;
                end
            end
            DATA: begin
                if (done) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_DATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (grant_data) begin
            valid_d = 1'b1;
            write_d = mem_store;
            addr_d  = {mem_address[31:2], 2'b00};
            wdata_d = mem_store ? lsa_wdata : '0;
            wstrb_d = mem_store ? lsa_wstrb : '0;
        end else if (grant_fetch) begin
            valid_d = 1'b1;
            write_d = 1'b0;
            addr_d  = {fetch_addr[31:2], 2'b00};
            wdata_d = '0;
            wstrb_d = '0;
        end else if (done) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            valid_q <= valid_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign ext.valid = valid_q;
    assign ext.write = write_q;
    assign ext.addr  = addr_q;
    assign ext.wdata = wdata_q;
    assign ext.wstrb = wstrb_q;

    always_comb begin
        fetch_ready   = (state_q == FETCH) && done;
        mem_ready     = (state_q == DATA) && done;
        bus_error     = timeout;
        fetch_data    = (fetch_ready && !timeout) ? ext.rdata : '0;
        mem_load_data = (mem_ready && !timeout) ? lsa_load : '0;
        stall_fetch   = fetch_req && !fetch_ready;
        stall_mem     = mem_req && !mem_ready;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: fetch, arbitration ties, sub-word lanes, async reset, timeout.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        mem_load;
    logic        mem_store;
    logic [31:0] mem_address;
    logic [31:0] mem_store_data;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [31:0] mem_load_data;
    logic        mem_ready;
    logic        stall_fetch;
    logic        stall_mem;
    logic        bus_error;

    int unsigned checks = 0;
    int unsigned errors = 0;

    bus_arbiter_if ext_bus ();

    bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_data     (fetch_data),
        .fetch_ready    (fetch_ready),
        .mem_load       (mem_load),
        .mem_store      (mem_store),
        .mem_address    (mem_address),
        .mem_store_data (mem_store_data),
        .mem_size       (mem_size),
        .mem_signed     (mem_signed),
        .mem_load_data  (mem_load_data),
        .mem_ready      (mem_ready),
        .stall_fetch    (stall_fetch),
        .stall_mem      (stall_mem),
        .bus_error      (bus_error),
        .ext            (ext_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        mem_load = 1'b0; mem_store = 1'b0; mem_address = '0; mem_store_data = '0;
        mem_size = SIZE_WORD; mem_signed = 1'b0;
        ext_bus.ready = 1'b0; ext_bus.rdata = '0;

        cyc(); cyc(); #1;
        chk("rst_valid", ext_bus.valid, 0);
        chk("rst_write", ext_bus.write, 0);
        chk("rst_addr", ext_bus.addr, 0);
        chk("rst_wdata", ext_bus.wdata, 0);
        chk("rst_wstrb", ext_bus.wstrb, 0);
        chk("rst_err", bus_error, 0);
        chk("rst_fready", fetch_ready, 0);
        rst_n = 1'b1;

        // fetch only, three wait cycles before ext ready
        cyc();
        fetch_req = 1'b1; fetch_addr = 32'h100; #1;
        chk("f_stall_idle", stall_fetch, 1);
        chk("f_valid_idle", ext_bus.valid, 0);
        cyc(); #1;
        chk("f_valid", ext_bus.valid, 1);
        chk("f_addr", ext_bus.addr, 32'h100);
        chk("f_write", ext_bus.write, 0);
        chk("f_wstrb", ext_bus.wstrb, 0);
        chk("f_ready_w1", fetch_ready, 0);
        cyc(); #1;
        chk("f_ready_w2", fetch_ready, 0);
        cyc(); #1;
        chk("f_ready_w3", fetch_ready, 0);
        chk("f_stall_w3", stall_fetch, 1);
        cyc();
        ext_bus.ready = 1'b1; ext_bus.rdata = 32'h0000_0013; #1;
        chk("f_ready", fetch_ready, 1);
        chk("f_data", fetch_data, 32'h13);
        chk("f_stall_done", stall_fetch, 0);
        cyc();
        fetch_req = 1'b0; ext_bus.ready = 1'b0; #1;
        chk("f_valid_after", ext_bus.valid, 0);
        chk("f_ready_after", fetch_ready, 0);

        // first tie after reset goes to data; signed byte load
        fetch_req = 1'b1; fetch_addr = 32'h104;
        mem_load = 1'b1; mem_address = 32'h203; mem_size = SIZE_BYTE; mem_signed = 1'b1; #1;
        chk("tie1_mstall", stall_mem, 1);
        cyc(); #1;
        chk("tie1_valid", ext_bus.valid, 1);
        chk("tie1_addr", ext_bus.addr, 32'h200);
        ext_bus.ready = 1'b1; ext_bus.rdata = 32'h80FF_0000; #1;
        chk("lb_ready", mem_ready, 1);
        chk("lb_data", mem_load_data, 32'hFFFF_FF80);
        chk("tie1_fready", fetch_ready, 0);
        chk("tie1_fstall", stall_fetch, 1);
        cyc();
        ext_bus.ready = 1'b0; mem_address = 32'h202; mem_size = SIZE_HALF; mem_signed = 1'b0; #1;
        chk("tie2_idle_valid", ext_bus.valid, 0);
        chk("tie2_idle_mready", mem_ready, 0);

        // second tie goes to fetch
        cyc(); #1;
        chk("tie2_addr", ext_bus.addr, 32'h104);
        chk("tie2_mstall", stall_mem, 1);
        ext_bus.ready = 1'b1; ext_bus.rdata = 32'h0010_0093; #1;
        chk("tie2_fready", fetch_ready, 1);
        chk("tie2_fdata", fetch_data, 32'h0010_0093);
        chk("tie2_mready", mem_ready, 0);
        cyc();
        fetch_req = 1'b0; ext_bus.ready = 1'b0; #1;

        // unsigned half load
        cyc(); #1;
        chk("lh_addr", ext_bus.addr, 32'h200);
        ext_bus.ready = 1'b1; ext_bus.rdata = 32'hBEEF_1234; #1;
        chk("lh_ready", mem_ready, 1);
        chk("lh_data", mem_load_data, 32'h0000_BEEF);
        cyc();
        mem_load = 1'b0; ext_bus.ready = 1'b0;

        // half store with one wait cycle
        mem_store = 1'b1; mem_address = 32'h302; mem_size = SIZE_HALF; mem_store_data = 32'h0000_ABCD;
        cyc(); #1;
        chk("sh_valid", ext_bus.valid, 1);
        chk("sh_write", ext_bus.write, 1);
        chk("sh_addr", ext_bus.addr, 32'h300);
        chk("sh_wdata", ext_bus.wdata, 32'hABCD_ABCD);
        chk("sh_wstrb", ext_bus.wstrb, 32'hC);
        chk("sh_mready", mem_ready, 0);
        cyc(); #1;
        chk("sh_hold_wdata", ext_bus.wdata, 32'hABCD_ABCD);
        chk("sh_hold_wstrb", ext_bus.wstrb, 32'hC);
        ext_bus.ready = 1'b1; #1;
        chk("sh_ready", mem_ready, 1);
        chk("sh_stall", stall_mem, 0);
        cyc();
        ext_bus.ready = 1'b0;

        // byte store
        mem_address = 32'h301; mem_size = SIZE_BYTE; mem_store_data = 32'h0000_005A;
        cyc(); #1;
        chk("sb_wdata", ext_bus.wdata, 32'h5A5A_5A5A);
        chk("sb_wstrb", ext_bus.wstrb, 32'h2);
        ext_bus.ready = 1'b1; #1;
        chk("sb_ready", mem_ready, 1);
        cyc();
        mem_store = 1'b0; ext_bus.ready = 1'b0;

        // asynchronous reset while a load waits
        mem_load = 1'b1; mem_address = 32'h400; mem_size = SIZE_WORD;
        cyc(); #1;
        chk("rm_valid", ext_bus.valid, 1);
        cyc();
        rst_n = 1'b0; #1;
        chk("rm_valid_rst", ext_bus.valid, 0);
        chk("rm_mready_rst", mem_ready, 0);
        cyc();
        rst_n = 1'b1; mem_load = 1'b0; ext_bus.ready = 1'b1; #1;
        chk("rm_idle_ready_ignored", mem_ready, 0);
        chk("rm_valid_after", ext_bus.valid, 0);
        cyc();
        ext_bus.ready = 1'b0; #1;
        chk("rm_idle_valid", ext_bus.valid, 0);

`ifdef BUS_ARB_TIMEOUT_EN
        mem_load = 1'b1; mem_address = 32'h500; ext_bus.rdata = 32'hDEAD_BEEF;
        cyc(); #1;
        chk("to_valid", ext_bus.valid, 1);
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_err", bus_error, 0);
            chk("to_wait_ready", mem_ready, 0);
            cyc(); #1;
        end
        chk("to_err", bus_error, 1);
        chk("to_ready", mem_ready, 1);
        chk("to_data", mem_load_data, 0);
        cyc();
        mem_load = 1'b0; #1;
        chk("to_valid_after", ext_bus.valid, 0);
        chk("to_err_after", bus_error, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
